// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs req/ack reads to instruction memory and loads the IF/ID buffer.
// Optional performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] ifid_pc_add_o,
  output logic [15:0] ifid_inst_o,
  output logic        ifid_enable_o,
  output logic        ifid_flush_n_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [15:0] perf_delivered_o,
  output logic [15:0] perf_bubble_o
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] stale_addr_q, stale_addr_d;
  logic [15:0] pc_add_q, pc_add_d;
  logic [15:0] inst_q, inst_d;
  logic        enable_q, enable_d;
  logic        flush_n_q, flush_n_d;

  logic [15:0] pc_inc;
  logic [15:0] target;

  assign pc_inc = pc_q + 16'd2;
  assign target = {redirect_pc_i[15:1], 1'b0};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      stale_addr_q <= 16'h0000;
      pc_add_q     <= 16'h0000;
      inst_q       <= 16'h0000;
      enable_q     <= 1'b0;
      flush_n_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      pc_add_q     <= pc_add_d;
      inst_q       <= inst_d;
      enable_q     <= enable_d;
      flush_n_q    <= flush_n_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    pc_add_d     = pc_add_q;
    inst_d       = inst_q;
    enable_d     = 1'b0;
    flush_n_d    = 1'b1;
    if (redirect_i) begin
      pc_d      = target;
      flush_n_d = 1'b0;
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH: begin
          // An unacked request must still be completed, so remember its address.
          if (!imem_ack_i) begin
            stale_addr_d = pc_q;
            state_d      = DISCARD;
          end
        end
        HOLD:    state_d = FETCH;
        default: state_d = DISCARD;
      endcase
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH: begin
          if (imem_ack_i) begin
            inst_d   = imem_rdata_i;
            pc_add_d = pc_inc;
            pc_d     = pc_inc;
            if (stall_i) state_d = HOLD;
            else         enable_d = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            enable_d = 1'b1;
            state_d  = FETCH;
          end
        end
        default: begin
          if (imem_ack_i) state_d = FETCH;
        end
      endcase
    end
  end

  assign imem_req_o     = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr_o    = (state_q == DISCARD) ? stale_addr_q : pc_q;
  assign ifid_pc_add_o  = pc_add_q;
  assign ifid_inst_o    = inst_q;
  assign ifid_enable_o  = enable_q;
  assign ifid_flush_n_o = flush_n_q;

`ifdef IF_FETCH_PERF_EN
  logic [15:0] delivered_q;
  logic [15:0] bubble_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      delivered_q <= 16'h0000;
      bubble_q    <= 16'h0000;
    end else begin
      if (enable_q && (delivered_q != 16'hFFFF))
        delivered_q <= delivered_q + 16'd1;
      if ((state_q != IDLE) && !enable_q && (bubble_q != 16'hFFFF))
        bubble_q <= bubble_q + 16'd1;
    end
  end

  assign perf_delivered_o = delivered_q;
  assign perf_bubble_o    = bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model with programmable wait states, checks sampled on the falling edge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_pc_add;
  logic [15:0] ifid_inst;
  logic        ifid_enable;
  logic        ifid_flush_n;
`ifdef IF_FETCH_PERF_EN
  logic [15:0] perf_delivered;
  logic [15:0] perf_bubble;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] wait_n = 2'd0;
  logic [1:0] cnt;

  if_fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .ifid_pc_add_o  (ifid_pc_add),
    .ifid_inst_o    (ifid_inst),
    .ifid_enable_o  (ifid_enable),
    .ifid_flush_n_o (ifid_flush_n)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_delivered_o (perf_delivered),
    .perf_bubble_o    (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory acks after wait_n extra request cycles.
  assign imem_ack   = imem_req && (cnt == wait_n);
  assign imem_rdata = mem(imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= 2'd0;
    else if (!imem_req || imem_ack) cnt <= 2'd0;
    else                         cnt <= cnt + 2'd1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_req",     16'(imem_req), 16'h0);
    chk("rst_flush_n", 16'(ifid_flush_n), 16'h0);
    chk("rst_en",      16'(ifid_enable), 16'h0);
    chk("rst_pc_add",  ifid_pc_add, 16'h0000);
    chk("rst_inst",    ifid_inst, 16'h0000);
    chk("rst_addr",    imem_addr, 16'h0100);
`ifdef IF_FETCH_PERF_EN
    chk("rst_perf_d",  perf_delivered, 16'h0000);
    chk("rst_perf_b",  perf_bubble, 16'h0000);
`endif
    rst = 1'b0;
    // zero-wait streaming from RESET_PC
    cyc();
    chk("z_req1",   16'(imem_req), 16'h1);
    chk("z_addr1",  imem_addr, 16'h0100);
    chk("z_flush1", 16'(ifid_flush_n), 16'h1);
    chk("z_en1",    16'(ifid_enable), 16'h0);
    cyc();
    chk("z_en2",     16'(ifid_enable), 16'h1);
    chk("z_pcadd2",  ifid_pc_add, 16'h0102);
    chk("z_inst2",   ifid_inst, mem(16'h0100));
    chk("z_addr2",   imem_addr, 16'h0102);
    cyc();
    chk("z_addr3",   imem_addr, 16'h0104);
    chk("z_pcadd3",  ifid_pc_add, 16'h0104);
    chk("z_inst3",   ifid_inst, mem(16'h0102));
    // two-wait memory
    wait_n = 2'd2;
    cyc();
    chk("w_addr4", imem_addr, 16'h0104);
    chk("w_en4",   16'(ifid_enable), 16'h0);
    cyc();
    chk("w_addr5", imem_addr, 16'h0104);
    chk("w_ack5",  16'(imem_ack), 16'h1);
    cyc();
    chk("w_en6",    16'(ifid_enable), 16'h1);
    chk("w_pcadd6", ifid_pc_add, 16'h0106);
    chk("w_inst6",  ifid_inst, mem(16'h0104));
    chk("w_addr6",  imem_addr, 16'h0106);
    cyc();
    chk("w_en7",   16'(ifid_enable), 16'h0);
    chk("w_addr7", imem_addr, 16'h0106);
    cyc();
    chk("w_en8",   16'(ifid_enable), 16'h0);
    chk("w_addr8", imem_addr, 16'h0106);
    cyc();
    chk("w_en9",    16'(ifid_enable), 16'h1);
    chk("w_pcadd9", ifid_pc_add, 16'h0108);
    chk("w_inst9",  ifid_inst, mem(16'h0106));
    chk("w_addr9",  imem_addr, 16'h0108);
    // stall across an ack
    wait_n = 2'd0;
    stall  = 1'b1;
    cyc();
    chk("s_req10",   16'(imem_req), 16'h0);
    chk("s_en10",    16'(ifid_enable), 16'h0);
    chk("s_inst10",  ifid_inst, mem(16'h0108));
    chk("s_pcadd10", ifid_pc_add, 16'h010A);
    cyc();
    chk("s_en11", 16'(ifid_enable), 16'h0);
    cyc();
    chk("s_req12",  16'(imem_req), 16'h0);
    chk("s_inst12", ifid_inst, mem(16'h0108));
    cyc();
    chk("s_en13", 16'(ifid_enable), 16'h0);
    stall = 1'b0;
    cyc();
    chk("s_en14",    16'(ifid_enable), 16'h1);
    chk("s_inst14",  ifid_inst, mem(16'h0108));
    chk("s_pcadd14", ifid_pc_add, 16'h010A);
    chk("s_addr14",  imem_addr, 16'h010A);
    chk("s_req14",   16'(imem_req), 16'h1);
    cyc();
    chk("s_en15",    16'(ifid_enable), 16'h1);
    chk("s_pcadd15", ifid_pc_add, 16'h010C);
    chk("s_inst15",  ifid_inst, mem(16'h010A));
    // redirect during an outstanding two-wait request at 010C
    wait_n      = 2'd2;
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    cyc();
    chk("r_flush16", 16'(ifid_flush_n), 16'h0);
    chk("r_en16",    16'(ifid_enable), 16'h0);
    chk("r_addr16",  imem_addr, 16'h010C);
    chk("r_req16",   16'(imem_req), 16'h1);
    redirect = 1'b0;
    cyc();
    chk("r_flush17", 16'(ifid_flush_n), 16'h1);
    chk("r_addr17",  imem_addr, 16'h010C);
    chk("r_ack17",   16'(imem_ack), 16'h1);
    cyc();
    chk("r_addr18",  imem_addr, 16'h0200);
    chk("r_en18",    16'(ifid_enable), 16'h0);
    // redirect to 0041 while the request at 0200 waits
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    cyc();
    chk("d_flush19", 16'(ifid_flush_n), 16'h0);
    chk("d_addr19",  imem_addr, 16'h0200);
    chk("d_en19",    16'(ifid_enable), 16'h0);
    redirect = 1'b0;
    cyc();
    chk("d_flush20", 16'(ifid_flush_n), 16'h1);
    chk("d_addr20",  imem_addr, 16'h0200);
    chk("d_ack20",   16'(imem_ack), 16'h1);
    cyc();
    chk("d_addr21", imem_addr, 16'h0040);
    chk("d_en21",   16'(ifid_enable), 16'h0);
    cyc();
    chk("d_en22", 16'(ifid_enable), 16'h0);
    cyc();
    chk("d_ack23",  16'(imem_ack), 16'h1);
    chk("d_addr23", imem_addr, 16'h0040);
    cyc();
    chk("d_en24",    16'(ifid_enable), 16'h1);
    chk("d_pcadd24", ifid_pc_add, 16'h0042);
    chk("d_inst24",  ifid_inst, mem(16'h0040));
    // redirect together with stall from HOLD
    wait_n = 2'd0;
    stall  = 1'b1;
    cyc();
    chk("h_req25",  16'(imem_req), 16'h0);
    chk("h_inst25", ifid_inst, mem(16'h0042));
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    cyc();
    chk("h_flush26", 16'(ifid_flush_n), 16'h0);
    chk("h_en26",    16'(ifid_enable), 16'h0);
    chk("h_addr26",  imem_addr, 16'h1234);
    chk("h_req26",   16'(imem_req), 16'h1);
    redirect = 1'b0;
    cyc();
    chk("h_flush27", 16'(ifid_flush_n), 16'h1);
    chk("h_en27",    16'(ifid_enable), 16'h0);
    chk("h_req27",   16'(imem_req), 16'h0);
    chk("h_inst27",  ifid_inst, mem(16'h1234));
    chk("h_pcadd27", ifid_pc_add, 16'h1236);
    stall = 1'b0;
    cyc();
    chk("h_en28",    16'(ifid_enable), 16'h1);
    chk("h_inst28",  ifid_inst, mem(16'h1234));
    chk("h_addr28",  imem_addr, 16'h1236);
    // redirect with ack in FETCH to odd FFFF -> FFFE, then wrap
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    cyc();
    chk("p_flush29", 16'(ifid_flush_n), 16'h0);
    chk("p_en29",    16'(ifid_enable), 16'h0);
    chk("p_addr29",  imem_addr, 16'hFFFE);
    redirect = 1'b0;
    cyc();
    chk("p_en30",    16'(ifid_enable), 16'h1);
    chk("p_pcadd30", ifid_pc_add, 16'h0000);
    chk("p_inst30",  ifid_inst, mem(16'hFFFE));
    chk("p_addr30",  imem_addr, 16'h0000);
    // back-to-back redirects
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    cyc();
    chk("b_flush31", 16'(ifid_flush_n), 16'h0);
    chk("b_en31",    16'(ifid_enable), 16'h0);
    chk("b_addr31",  imem_addr, 16'h0300);
    redirect_pc = 16'h0400;
    cyc();
    chk("b_flush32", 16'(ifid_flush_n), 16'h0);
    chk("b_en32",    16'(ifid_enable), 16'h0);
    chk("b_addr32",  imem_addr, 16'h0400);
    redirect = 1'b0;
    cyc();
    chk("b_flush33", 16'(ifid_flush_n), 16'h1);
    chk("b_en33",    16'(ifid_enable), 16'h1);
    chk("b_pcadd33", ifid_pc_add, 16'h0402);
    chk("b_inst33",  ifid_inst, mem(16'h0400));
    // reset in the middle of a waiting request
    wait_n = 2'd2;
    cyc();
    chk("m_req34",  16'(imem_req), 16'h1);
    chk("m_addr34", imem_addr, 16'h0402);
    rst = 1'b1;
    #1;
    chk("m_req_rst",   16'(imem_req), 16'h0);
    chk("m_flush_rst", 16'(ifid_flush_n), 16'h0);
    chk("m_en_rst",    16'(ifid_enable), 16'h0);
    chk("m_addr_rst",  imem_addr, 16'h0100);
`ifdef IF_FETCH_PERF_EN
    chk("m_perf_d_rst", perf_delivered, 16'h0000);
    chk("m_perf_b_rst", perf_bubble, 16'h0000);
`endif
    cyc();
    rst    = 1'b0;
    wait_n = 2'd0;
    cyc();
    chk("m_req36",  16'(imem_req), 16'h1);
    chk("m_addr36", imem_addr, 16'h0100);
`ifdef IF_FETCH_PERF_EN
    chk("m_perf_b36", perf_bubble, 16'h0000);
`endif
    cyc();
    chk("m_en37",    16'(ifid_enable), 16'h1);
    chk("m_pcadd37", ifid_pc_add, 16'h0102);
`ifdef IF_FETCH_PERF_EN
    chk("m_perf_d37", perf_delivered, 16'h0000);
    chk("m_perf_b37", perf_bubble, 16'h0001);
`endif
    cyc();
    chk("m_pcadd38", ifid_pc_add, 16'h0104);
`ifdef IF_FETCH_PERF_EN
    chk("m_perf_d38", perf_delivered, 16'h0001);
    chk("m_perf_b38", perf_bubble, 16'h0001);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
